stopwatch_display: RTL and testbench



---
 rtl/stopwatch_display.sv | 162 ++++++++++++++++
 tb/tb_stopwatch_display.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_display.sv
// stopwatch_display
// Counts one-second tick pulses as an MM:SS BCD value (00:00-59:59) and
// drives a time-multiplexed 4-digit common-anode 7-segment display.
// A hold (lap) input freezes the shown value while counting continues.
//
// Handshake: tick, clear and hold are plain levels sampled on every rising
// clock edge; there is no valid/ready pair because the consumer can always
// accept a tick (back-to-back ticks are each counted).
//
// Pipeline from a tick to the pins:
//   edge 1: time digits update (and rollover pulses if 59:59 wrapped)
//   edge 2: disp snapshot loads the new time (when hold is low)
//   edge 3: seg shows the new digit if that digit is currently selected

module stopwatch_display #(
  parameter int REFRESH_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       clear,
  input  logic       hold,
  output logic       rollover,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  // Refresh counter wide enough to hold REFRESH_CYCLES-1.
  localparam int CW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_CYCLES - 1);

  // Scan state names the digit slot that is currently lit.
  typedef enum logic [1:0] {
    DIG_SU = 2'd0,   // seconds units (rightmost)
    DIG_ST = 2'd1,   // seconds tens
    DIG_MU = 2'd2,   // minutes units (decimal point lit here)
    DIG_MT = 2'd3    // minutes tens (leftmost)
  } digit_t;

  // Time digits, BCD.
  logic [3:0] s_u;
  logic [3:0] s_t;
  logic [3:0] m_u;
  logic [3:0] m_t;

  // Display snapshot {m_t, m_u, s_t, s_u}.
  logic [15:0] disp;

  // Scan state.
  logic [CW-1:0] ref_cnt;
  digit_t        idx;
  digit_t        idx_nxt;
  logic          ref_last;
  logic [3:0]    nib_nxt;

  // Active-low segment decode in {g,f,e,d,c,b,a} order; codes above 9 blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic time_at_max;
  assign time_at_max = (s_u == 4'd9) && (s_t == 4'd5) &&
                       (m_u == 4'd9) && (m_t == 4'd5);

  // Time digits: BCD ripple increment on tick, clear wins over tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_u      <= 4'd0;
      s_t      <= 4'd0;
      m_u      <= 4'd0;
      m_t      <= 4'd0;
      rollover <= 1'b0;
    end else begin
      rollover <= 1'b0;
      if (clear) begin
        s_u <= 4'd0;
        s_t <= 4'd0;
        m_u <= 4'd0;
        m_t <= 4'd0;
      end else if (tick) begin
        rollover <= time_at_max;
        if (s_u == 4'd9) begin
          s_u <= 4'd0;
          if (s_t == 4'd5) begin
            s_t <= 4'd0;
            if (m_u == 4'd9) begin
              m_u <= 4'd0;
              if (m_t == 4'd5) begin
                m_t <= 4'd0;
              end else begin
                m_t <= m_t + 4'd1;
              end
            end else begin
              m_u <= m_u + 4'd1;
            end
          end else begin
            s_t <= s_t + 4'd1;
          end
        end else begin
          s_u <= s_u + 4'd1;
        end
      end
    end
  end

  // Display snapshot: follows the time while hold is low, frozen otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp <= 16'h0000;
    end else if (!hold) begin
      disp <= {m_t, m_u, s_t, s_u};
    end
  end

  // Next scan slot and the nibble it will show; computed ahead so that an,
  // seg and dp all switch on the same edge.
  always_comb begin
    ref_last = (ref_cnt == REF_LAST);
    idx_nxt  = ref_last ? digit_t'(idx + 2'd1) : idx;
    nib_nxt  = 4'd0;
    case (idx_nxt)
      DIG_SU:  nib_nxt = disp[3:0];
      DIG_ST:  nib_nxt = disp[7:4];
      DIG_MU:  nib_nxt = disp[11:8];
      DIG_MT:  nib_nxt = disp[15:12];
      default: nib_nxt = 4'hF;
    endcase
  end

  // Scan FSM with registered digit enable, segment and decimal-point outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt <= '0;
      idx     <= DIG_SU;
      an      <= 4'b1110;
      seg     <= 7'b1000000;
      dp      <= 1'b1;
    end else begin
      ref_cnt <= ref_last ? '0 : ref_cnt + 1'b1;
      idx     <= idx_nxt;
      an      <= ~(4'b0001 << idx_nxt);
      seg     <= seg_decode(nib_nxt);
      dp      <= (idx_nxt != DIG_MU);
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Bench for stopwatch_display. A reference model keeps time as a plain
// count of seconds and derives the expected display from it each cycle;
// scenario steps additionally read the time back off the display pins.

module tb_stopwatch_display;

  localparam int R = 4;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       clear;
  logic       hold;
  logic       rollover;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_chk  = 0;
  int n_pass = 0;

  stopwatch_display #(.REFRESH_CYCLES(R)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .clear    (clear),
    .hold     (hold),
    .rollover (rollover),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] dig_of_seg(input logic [6:0] s);
    for (int i = 0; i < 10; i++) begin
      if (seg_of(i) == s) return 4'(i);
    end
    return 4'hF;
  endfunction

  // Digit k (0 = seconds units .. 3 = minutes tens) of a seconds count.
  function automatic int digit_of(input int secs, input int k);
    int m;
    int s;
    m = secs / 60;
    s = secs % 60;
    case (k)
      0: return s % 10;
      1: return s / 10;
      2: return m % 10;
      default: return m / 10;
    endcase
  endfunction

  // ---------------- reference model ----------------
  int m_secs      = 0;  // running time in seconds
  int m_disp      = 0;  // snapshot in seconds
  int m_disp_prev = 0;  // snapshot one edge earlier (what seg is built from)
  int m_scan      = 0;  // edges since reset
  bit m_roll      = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_secs      <= 0;
      m_disp      <= 0;
      m_disp_prev <= 0;
      m_scan      <= 0;
      m_roll      <= 1'b0;
    end else begin
      m_disp_prev <= m_disp;
      if (!hold) m_disp <= m_secs;
      m_scan <= m_scan + 1;
      if (clear) begin
        m_secs <= 0;
        m_roll <= 1'b0;
      end else if (tick) begin
        m_secs <= (m_secs + 1) % 3600;
        m_roll <= (m_secs == 3599);
      end else begin
        m_roll <= 1'b0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  bit chk_en   = 1'b0;
  int roll_seen = 0;

  always @(negedge clk) begin
    int         k;
    logic [3:0] sel;
    if (chk_en) begin
      k   = (m_scan / R) % 4;
      sel = 4'b0001 << k;
      check("an",       {28'd0, an},       {28'd0, ~sel});
      check("seg",      {25'd0, seg},      {25'd0, seg_of(digit_of(m_disp_prev, k))});
      check("dp",       {31'd0, dp},       {31'd0, (k != 2)});
      check("rollover", {31'd0, rollover}, {31'd0, m_roll});
    end
    if (rollover) roll_seen <= roll_seen + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  // Ticks with random spacing 0..max_gap idle cycles (0 = back-to-back).
  task automatic ticks(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      do_tick();
      idle($urandom_range(0, max_gap));
    end
  endtask

  // Reads the shown MM:SS off the pins over one full scan.
  task automatic read_time(input string tag, input logic [15:0] exp);
    logic [15:0] got;
    logic [3:0]  sel;
    got = 16'hFFFF;
    idle(3);
    for (int c = 0; c < 4 * R; c++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        sel = 4'b0001 << d;
        if (an == ~sel) got[4*d +: 4] = dig_of_seg(seg);
      end
    end
    check(tag, {16'd0, got}, {16'd0, exp});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int roll_base;
    int waited;
    rst   = 1'b1;
    tick  = 1'b0;
    clear = 1'b0;
    hold  = 1'b0;
    idle(2);
    chk_en = 1'b1;

    // Reset values and idle scan.
    check("rst_an",  {28'd0, an},  32'h0000000E);
    check("rst_seg", {25'd0, seg}, 32'h00000040);
    check("rst_dp",  {31'd0, dp},  32'h1);
    rst = 1'b0;
    idle(4 * R + 3);

    // 60 ticks with mixed spacing -> 01:00, no rollover.
    roll_base = roll_seen;
    ticks(60, 3);
    read_time("t60", 16'h0100);
    check("t60_noroll", roll_seen - roll_base, 0);

    // 3599 ticks -> 59:59, one more -> 00:00 with a single rollover pulse.
    do_reset();
    ticks(3599, 1);
    read_time("t3599", 16'h5959);
    roll_base = roll_seen;
    do_tick();
    check("wrap_pulse", {31'd0, rollover}, 32'h1);
    idle(1);
    check("wrap_pulse_end", {31'd0, rollover}, 32'h0);
    read_time("t3600", 16'h0000);
    check("wrap_count", roll_seen - roll_base, 1);

    // clear beats a same-cycle tick.
    do_reset();
    ticks(7, 2);
    read_time("t7", 16'h0007);
    roll_base = roll_seen;
    clear = 1'b1;
    tick  = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    tick  = 1'b0;
    read_time("clr_tick", 16'h0000);
    check("clr_noroll", roll_seen - roll_base, 0);
    do_tick();
    read_time("after_clr", 16'h0001);

    // hold freezes display while counting continues.
    do_reset();
    ticks(5, 2);
    idle(3);
    hold = 1'b1;
    ticks(10, 2);
    read_time("held", 16'h0005);
    hold = 1'b0;
    read_time("released", 16'h0015);

    // clear under hold clears time but not the frozen display.
    hold = 1'b1;
    idle(1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    read_time("held_clr", 16'h0015);
    hold = 1'b0;
    read_time("held_clr_rel", 16'h0000);

    // Reset at 12:34 while the minutes-units digit is lit.
    do_reset();
    ticks(754, 0);
    waited = 0;
    while (an != 4'b1011 && waited < 4 * R + 2) begin
      @(negedge clk);
      waited++;
    end
    check("idx2_reached", {28'd0, an}, 32'h0000000B);
    rst  = 1'b1;
    tick = 1'b1;
    hold = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    tick = 1'b0;
    hold = 1'b0;
    check("midrst_an",   {28'd0, an},       32'h0000000E);
    check("midrst_seg",  {25'd0, seg},      32'h00000040);
    check("midrst_roll", {31'd0, rollover}, 32'h0);
    read_time("midrst_time", 16'h0000);

    // Random traffic; the per-cycle model checks everything.
    for (int i = 0; i < 1500; i++) begin
      tick  = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 30) == 0) hold = ~hold;
      rst   = ($urandom_range(0, 400) == 0);
      @(negedge clk);
    end
    tick  = 1'b0;
    clear = 1'b0;
    hold  = 1'b0;
    rst   = 1'b0;
    idle(4 * R);

    // Near-wrap random spacing to exercise rollover against the model.
    do_reset();
    ticks(3595, 0);
    ticks(10, 2);
    read_time("rand_wrap", 16'h0005);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
